// File: rtl/dmem_dump_ctrl_pkg.sv
// Shared definitions for the halt-detect / dmem dump engine: FSM state encoding and the
// default halt PC (address of the ebreak in startup.s).
package dmem_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    DdIdle = 3'd0,
    DdRead = 3'd1,
    DdWait = 3'd2,
    DdSend = 3'd3,
    DdDone = 3'd4
  } dd_state_e;

  localparam logic [31:0] DefaultHaltPc = 32'h0000_0064;

endpackage

// File: rtl/dump_byte_ser.sv
// Holds one 32-bit dmem word and emits it as four bytes, LSB first, over valid/ready.
// last flags the byte whose transfer completes the word.
module dump_byte_ser (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        ready,
  output logic        valid,
  output logic [7:0]  data,
  output logic        last
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= load_word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      if (idx_q == 2'd3) begin
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  assign valid = valid_q;
  assign last  = (idx_q == 2'd3);
  // Data is forced to zero whenever no byte is offered so idle/reset output is clean.
  assign data  = valid_q ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Halt-detect and dmem dump engine: on PC==HALT_PC it freezes the core, reads NUM_WORDS
// words from START_WORD through a dedicated read port and streams them out as bytes.
module dmem_dump_ctrl
  import dmem_dump_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_PC    = DefaultHaltPc,
  parameter int unsigned START_WORD = 0,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       pc,
  output logic              core_stall,
  output logic              dm_re,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_rdata,
  output logic              dout_valid,
  output logic [7:0]        dout_data,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       CntW      = $clog2(NUM_WORDS + 1);
  localparam logic [CntW-1:0]   LastCnt   = CntW'(NUM_WORDS - 1);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_WORD);
  localparam bit ParamOk = (NUM_WORDS >= 1) && ((START_WORD + NUM_WORDS) <= (32'd1 << ADDR_W));

  dd_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stall_q, stall_d;
  logic              ser_load;
  logic              ser_valid;
  logic              ser_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= DdIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    stall_d  = stall_q;
    ser_load = 1'b0;
    unique case (state_q)
      DdIdle: begin
        if (pc == HALT_PC) begin
          state_d = DdRead;
          stall_d = 1'b1;
          cnt_d   = '0;
          addr_d  = StartAddr;
        end
      end
      DdRead: state_d = DdWait;
      DdWait: begin
        // Read data is valid exactly one cycle after dm_re, i.e. now.
        ser_load = 1'b1;
        state_d  = DdSend;
      end
      DdSend: begin
        if (ser_valid && dout_ready && ser_last) begin
          if (cnt_q == LastCnt) begin
            state_d = DdDone;
          end else begin
            cnt_d   = cnt_q + CntOne;
            addr_d  = StartAddr + ADDR_W'(cnt_d);
            state_d = DdRead;
          end
        end
      end
      DdDone: state_d = DdDone;
      default: state_d = DdIdle;
    endcase
  end

  dump_byte_ser u_ser (
    .clk       (clk),
    .rstn      (rstn),
    .load      (ser_load),
    .load_word (dm_rdata),
    .ready     (dout_ready),
    .valid     (ser_valid),
    .data      (dout_data),
    .last      (ser_last)
  );

  assign core_stall = stall_q;
  assign dm_re      = (state_q == DdRead);
  assign dm_addr    = addr_q;
  assign dout_valid = ser_valid;
  assign busy       = (state_q == DdRead) || (state_q == DdWait) || (state_q == DdSend);
  assign done       = (state_q == DdDone);

  param_legal_a: assert property (@(posedge clk) ParamOk)
    else $error("dmem_dump_ctrl: illegal START_WORD/NUM_WORDS/ADDR_W combination");

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: three instances (2 words from 0, 4 words from 1020, 1 word from 5)
// share stimulus and are checked every cycle against a transaction-level model.
module tb_dmem_dump_ctrl;
  import dmem_dump_ctrl_pkg::*;

  localparam int unsigned NInst = 3;
  localparam int unsigned AddrW = 15;
  localparam int unsigned CfgStart [3] = '{0, 1020, 5};
  localparam int unsigned CfgNum   [3] = '{2, 4, 1};
  localparam logic [31:0] HaltPc = DefaultHaltPc;

  logic              clk = 1'b0;
  logic              rstn;
  logic [31:0]       pc;
  logic              ready;
  logic [2:0]        core_stall, dm_re, dout_valid, busy, done;
  logic [AddrW-1:0]  dm_addr   [3];
  logic [31:0]       dm_rdata  [3];
  logic [7:0]        dout_data [3];
  logic [31:0]       mem [0:1023];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: per instance, active/done flags, current word and position within the word
  // (0 = read cycle, 1 = read-latency cycle, 2..5 = byte 0..3 offered).
  bit               m_active [3];
  bit               m_done   [3];
  bit               m_stall  [3];
  int               m_word   [3];
  int               m_pos    [3];
  logic [AddrW-1:0] m_addr   [3];

  logic [7:0]       cap_byte [3][64];
  logic [AddrW-1:0] cap_addr [3][16];
  int               cap_n    [3];
  int               addr_n   [3];
  logic [31:0]      cmp_word;

  localparam logic [7:0] ExpA [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  localparam logic [7:0] ExpC [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
  localparam bit         RdyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    dmem_dump_ctrl #(
      .HALT_PC    (HaltPc),
      .START_WORD (CfgStart[g]),
      .NUM_WORDS  (CfgNum[g]),
      .ADDR_W     (AddrW)
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .pc         (pc),
      .core_stall (core_stall[g]),
      .dm_re      (dm_re[g]),
      .dm_addr    (dm_addr[g]),
      .dm_rdata   (dm_rdata[g]),
      .dout_valid (dout_valid[g]),
      .dout_data  (dout_data[g]),
      .dout_ready (ready),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
    end
  endtask

  // Memory read port (one-cycle latency) and the behavioural model.
  always @(posedge clk) begin
    for (int i = 0; i < NInst; i++) begin
      if (dm_re[i]) dm_rdata[i] <= mem[dm_addr[i]];
      if (!rstn) begin
        m_active[i] <= 1'b0;
        m_done[i]   <= 1'b0;
        m_stall[i]  <= 1'b0;
        m_word[i]   <= 0;
        m_pos[i]    <= 0;
        m_addr[i]   <= '0;
      end else if (m_active[i]) begin
        if (m_pos[i] < 2) begin
          m_pos[i] <= m_pos[i] + 1;
        end else if (ready) begin
          if (m_pos[i] < 5) begin
            m_pos[i] <= m_pos[i] + 1;
          end else if (m_word[i] < int'(CfgNum[i]) - 1) begin
            m_word[i] <= m_word[i] + 1;
            m_pos[i]  <= 0;
            m_addr[i] <= AddrW'(CfgStart[i] + 32'(m_word[i]) + 1);
          end else begin
            m_active[i] <= 1'b0;
            m_done[i]   <= 1'b1;
          end
        end
      end else if (!m_done[i] && pc == HaltPc) begin
        m_active[i] <= 1'b1;
        m_stall[i]  <= 1'b1;
        m_word[i]   <= 0;
        m_pos[i]    <= 0;
        m_addr[i]   <= AddrW'(CfgStart[i]);
      end
    end
  end

  // Compare process plus byte/address capture.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NInst; i++) begin
        chk("core_stall", i, 32'(core_stall[i]), 32'(m_stall[i]));
        chk("busy", i, 32'(busy[i]), 32'(m_active[i]));
        chk("done", i, 32'(done[i]), 32'(m_done[i]));
        chk("dm_re", i, 32'(dm_re[i]), 32'(m_active[i] && m_pos[i] == 0));
        chk("dm_addr", i, 32'(dm_addr[i]), 32'(m_addr[i]));
        chk("dout_valid", i, 32'(dout_valid[i]), 32'(m_active[i] && m_pos[i] >= 2));
        if (m_active[i] && m_pos[i] >= 2) begin
          cmp_word = mem[CfgStart[i] + 32'(m_word[i])];
          chk("dout_data", i, 32'(dout_data[i]), 32'(cmp_word[8*(m_pos[i]-2) +: 8]));
        end else if (!m_active[i] && !m_done[i]) begin
          chk("idle_data", i, 32'(dout_data[i]), 32'h0);
        end
        if (rstn && dout_valid[i] && ready && cap_n[i] < 64) begin
          cap_byte[i][cap_n[i]] = dout_data[i];
          cap_n[i]++;
        end
        if (rstn && dm_re[i] && addr_n[i] < 16) begin
          cap_addr[i][addr_n[i]] = dm_addr[i];
          addr_n[i]++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    for (int i = 0; i < NInst; i++) begin
      cap_n[i]  = 0;
      addr_n[i] = 0;
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < NInst; i++) begin
      chk({tag, "_stall"}, i, 32'(core_stall[i]), 32'h0);
      chk({tag, "_busy"}, i, 32'(busy[i]), 32'h0);
      chk({tag, "_done"}, i, 32'(done[i]), 32'h0);
      chk({tag, "_re"}, i, 32'(dm_re[i]), 32'h0);
      chk({tag, "_addr"}, i, 32'(dm_addr[i]), 32'h0);
      chk({tag, "_valid"}, i, 32'(dout_valid[i]), 32'h0);
      chk({tag, "_data"}, i, 32'(dout_data[i]), 32'h0);
    end
  endtask

  // Triggers a dump, runs until all instances finish; lat = cycles from stall to done[0].
  task automatic run_dump(input bit bp, output int lat);
    int n;
    lat = -1;
    n = 0;
    pc = HaltPc;
    step(1);
    pc = 32'h0000_0068;
    while (done != 3'b111 && n < 300) begin
      if (bp) ready = RdyPat[n % 4];
      step(1);
      n++;
      if (done[0] && lat < 0) lat = n;
    end
    ready = 1'b1;
    chk("dump_finished", 0, 32'(done), 32'h7);
  endtask

  task automatic check_streams(input string tag);
    chk({tag, "_a_count"}, 0, 32'(cap_n[0]), 32'd8);
    for (int j = 0; j < 8; j++) chk({tag, "_a_byte"}, j, 32'(cap_byte[0][j]), 32'(ExpA[j]));
    chk({tag, "_a_rd_count"}, 0, 32'(addr_n[0]), 32'd2);
    chk({tag, "_b_count"}, 1, 32'(cap_n[1]), 32'd16);
    for (int j = 0; j < 16; j++) chk({tag, "_b_byte"}, j, 32'(cap_byte[1][j]), 32'(16 + j));
    chk({tag, "_b_rd_count"}, 1, 32'(addr_n[1]), 32'd4);
    for (int j = 0; j < 4; j++) chk({tag, "_b_addr"}, j, 32'(cap_addr[1][j]), 32'(1020 + j));
    chk({tag, "_c_count"}, 2, 32'(cap_n[2]), 32'd4);
    for (int j = 0; j < 4; j++) chk({tag, "_c_byte"}, j, 32'(cap_byte[2][j]), 32'(ExpC[j]));
    chk({tag, "_c_addr"}, 0, 32'(cap_addr[2][0]), 32'd5);
    for (int i = 0; i < NInst; i++) begin
      chk({tag, "_stall_held"}, i, 32'(core_stall[i]), 32'h1);
      chk({tag, "_busy_low"}, i, 32'(busy[i]), 32'h0);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    clear_caps();
  endtask

  initial begin
    int lat;
    for (int a = 0; a < 1024; a++) mem[a] = 32'hA5A5_0000 | 32'(a);
    mem[0]    = 32'h4433_2211;
    mem[1]    = 32'hDDCC_BBAA;
    mem[5]    = 32'hCAFE_F00D;
    mem[1020] = 32'h1312_1110;
    mem[1021] = 32'h1716_1514;
    mem[1022] = 32'h1B1A_1918;
    mem[1023] = 32'h1F1E_1D1C;
    for (int i = 0; i < NInst; i++) dm_rdata[i] = '0;
    clear_caps();
    rstn  = 1'b0;
    pc    = 32'h0;
    ready = 1'b1;

    // Reset and idle
    step(2);
    chk_en = 1'b1;
    check_idle("reset");
    rstn = 1'b1;
    pc   = 32'h0000_0060;
    step(4);
    check_idle("near_pc");

    // Basic dump, ready held high
    run_dump(1'b0, lat);
    chk("stall_to_done_cycles", 0, 32'(lat), 32'd12);
    check_streams("basic");
    pc = HaltPc;
    step(3);
    pc = 32'h0;
    chk("done_sticky", 0, 32'(done), 32'h7);

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    check_idle("rst2");
    run_dump(1'b1, lat);
    check_streams("bp");

    // Reset during byte 2 of word 0, then re-trigger
    do_reset();
    pc = HaltPc;
    step(1);
    pc = 32'h0;
    step(3);
    chk("mid_byte", 0, 32'(dout_data[0]), 32'h22);
    rstn = 1'b0;
    step(1);
    check_idle("mid_rst");
    rstn = 1'b1;
    clear_caps();
    run_dump(1'b0, lat);
    check_streams("restart");

    // Halt PC seen again during SEND is ignored
    do_reset();
    pc = HaltPc;
    step(1);
    pc = 32'h0;
    step(3);
    pc = HaltPc;
    step(2);
    pc = 32'h0;
    run_dump(1'b0, lat);
    check_streams("retrig");

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
